lfsr_prbs_checker: RTL and testbench
====================================

Name: lfsr_prbs_checker

Overview:
Downstream consumer of the 8-bit Galois LFSR generator. Each valid cycle it takes the generator's parallel state word, self-synchronises to the sequence, then predicts every following word. It counts mismatches and reports lock/loss-of-lock for PRBS link and datapath integrity checks.

Parameters:
LENGTH, 8, LFSR width; bits indexed [LENGTH:1].
TAP, 8'b1100_1111, Galois tap vector [LENGTH:1]; must equal the generator's.
SYNC_MATCHES, 4, consecutive correct predictions required to declare lock (≥1).
LOSS_ERRORS, 3, consecutive mispredictions in lock that drop lock (≥1).
CNT_W, 16, error counter width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  in_state is a valid sample this cycle.
in_state  in  LENGTH  generator state word, [LENGTH:1].
clr_count  in  1  synchronous clear of err_count.
locked  out  1  registered; 1 while FSM is in LOCKED.
err_pulse  out  1  one-cycle pulse per mismatch counted in LOCKED.
sync_lost  out  1  one-cycle pulse on the LOCKED→HUNT transition.
err_count  out  CNT_W  saturating mismatch count, LOCKED state only.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Step function step(Y), identical to the generator:
  - next[1] = Y[LENGTH].
  - For k = 2..LENGTH: next[k] = Y[k-1] ^ (TAP[LENGTH-k+1] & Y[LENGTH]).
  - Defaults: step(0x91) = 0xD1; step(0xD1) = 0x51.
- Reset values: FSM = HUNT, exp = 0, match_cnt = 0, bad_cnt = 0, locked = 0, err_pulse = 0, sync_lost = 0, err_count = 0.
  - Reset mid-operation returns everything to these values immediately.
- When in_valid = 0, all state holds. err_pulse and sync_lost are driven 0 that cycle.
- HUNT, on a valid sample:
  - in_state == 0 is the lock-up word: ignore it and stay in HUNT.
  - Any other value: exp ← step(in_state), match_cnt ← 0, go to VERIFY.
- VERIFY, on a valid sample:
  - Match (in_state == exp): exp ← step(in_state), match_cnt++. When match_cnt+1 == SYNC_MATCHES, go to LOCKED; locked = 1 from the next cycle.
  - Mismatch, in_state nonzero: reseed with exp ← step(in_state), match_cnt ← 0, stay in VERIFY.
  - Mismatch, in_state == 0: go to HUNT.
  - Mismatches in VERIFY do not count as errors.
- LOCKED, on a valid sample:
  - Flywheel: exp ← step(exp) always. Never reseed from received data.
  - Match: bad_cnt ← 0.
  - Mismatch: err_pulse = 1 next cycle, err_count increments (saturates at all-ones), bad_cnt++.
  - When bad_cnt+1 == LOSS_ERRORS: go to HUNT, locked = 0 and sync_lost = 1 next cycle, bad_cnt ← 0. The err_pulse for that sample still fires, in the same cycle as sync_lost.
- Latency: all outputs are registered, one cycle after the sampling edge.
- clr_count has priority over a simultaneous increment: err_count becomes 0, err_pulse still fires.
- err_count holds its value across loss and regain of lock. Only reset or clr_count clears it.
- Counter widths: match_cnt is $clog2(SYNC_MATCHES+1) bits, bad_cnt is $clog2(LOSS_ERRORS+1) bits.

Decomposition:
- Shared package lfsr_pkg:
  - FSM state encodings: HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2.
  - Default LENGTH, TAP and seed (8'h91) constants, shared with the generator.
- Sub-module lfsr_step: purely combinational step(Y), parameterised by LENGTH and TAP.
  - The checker instantiates it twice: once on in_state (reseed path), once on exp (flywheel path).
  - The generator is retrofitted to use the same sub-module, so generator and checker cannot diverge.

Test Plan:
- Reset, then feed the generator sequence from 0x91 (0x91, 0xD1, 0x51, …) every cycle → locked rises 1 cycle after the 5th sample (seed + 4 matches); err_count stays 0.
- In lock, corrupt one sample (0xD1 → 0xD0), then resume the true sequence → single err_pulse, err_count = 1, locked stays 1, bad_cnt back to 0 on the next match.
- In lock, feed 3 consecutive wrong words → 3 err_pulses, err_count = 3, sync_lost pulse coincident with the 3rd err_pulse, locked = 0; resume the true sequence and lock is regained after 5 valid samples.
- Feed 0x00 repeatedly from reset, then 0x91 → stays in HUNT, no pulses; the 0x91 sample moves the FSM to VERIFY.
- Toggle in_valid in a 1-on/1-off pattern with the true sequence on the valid cycles only → locks after 5 valid samples; state holds on idle cycles.
- With err_count = 0xFFFF forced by repeated errors: a further error leaves it at 0xFFFF; clr_count together with an error gives err_count = 0 and err_pulse = 1. Assert rst_n low mid-lock → all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the Galois LFSR generator and the PRBS checker.
package lfsr_pkg;

  // Checker synchronisation states
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Default LFSR geometry, shared with the generator so both ends agree
  localparam int           LFSR_LENGTH = 8;
  localparam logic [8:1]   LFSR_TAP    = 8'b1100_1111;
  localparam logic [8:1]   LFSR_SEED   = 8'h91;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step; used by both the generator and the checker so the
// two implementations of the polynomial cannot drift apart.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               LENGTH = LFSR_LENGTH,
  parameter logic [LENGTH:1]  TAP    = LFSR_TAP
) (
  input  logic [LENGTH:1] y,
  output logic [LENGTH:1] next_y
);

  // Shift up by one, feed the MSB back to bit 1 and into every tapped stage
  always_comb begin
    next_y    = '0;
    next_y[1] = y[LENGTH];
    for (int k = 2; k <= LENGTH; k++) begin
      next_y[k] = y[k-1] ^ (TAP[LENGTH-k+1] & y[LENGTH]);
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// PRBS checker: self-synchronises to the generator's state words, then
// flywheels its own prediction and counts mismatches while locked.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int               LENGTH       = LFSR_LENGTH,
  parameter logic [LENGTH:1]  TAP          = LFSR_TAP,
  parameter int               SYNC_MATCHES = 4,
  parameter int               LOSS_ERRORS  = 3,
  parameter int               CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [LENGTH:1]   in_state,
  input  logic              clr_count,
  output logic              locked,
  output logic              err_pulse,
  output logic              sync_lost,
  output logic [CNT_W-1:0]  err_count
);

  localparam int MW = $clog2(SYNC_MATCHES + 1);
  localparam int BW = $clog2(LOSS_ERRORS + 1);

  chk_state_e        state_q, state_d;
  logic [LENGTH:1]   exp_q, exp_d;
  logic [MW-1:0]     match_cnt_q, match_cnt_d;
  logic [BW-1:0]     bad_cnt_q, bad_cnt_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic              sync_lost_q, sync_lost_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;

  logic [LENGTH:1]   step_in;
  logic [LENGTH:1]   step_exp;

  // Reseed path: successor of the received word
  lfsr_step #(.LENGTH(LENGTH), .TAP(TAP)) u_step_in (
    .y      (in_state),
    .next_y (step_in)
  );

  // Flywheel path: successor of our own prediction
  lfsr_step #(.LENGTH(LENGTH), .TAP(TAP)) u_step_exp (
    .y      (exp_q),
    .next_y (step_exp)
  );

  // Next-state, prediction, counters and output pulses
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_cnt_d = match_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_pulse_d = 1'b0;
    sync_lost_d = 1'b0;
    err_count_d = err_count_q;

    if (clr_count) begin
      err_count_d = '0;
    end

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (in_state != '0) begin
            exp_d       = step_in;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (in_state == exp_q) begin
            exp_d       = step_in;
            match_cnt_d = match_cnt_q + MW'(1);
            if (int'(match_cnt_q) + 1 == SYNC_MATCHES) begin
              state_d = LOCKED;
            end
          end else if (in_state != '0) begin
            exp_d       = step_in;
            match_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          exp_d = step_exp;
          if (in_state == exp_q) begin
            bad_cnt_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (!clr_count && (err_count_q != '1)) begin
              err_count_d = err_count_q + CNT_W'(1);
            end
            if (int'(bad_cnt_q) + 1 == LOSS_ERRORS) begin
              state_d     = HUNT;
              sync_lost_d = 1'b1;
              bad_cnt_d   = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + BW'(1);
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      match_cnt_q <= '0;
      bad_cnt_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_cnt_q <= match_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_lost_q <= sync_lost_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign sync_lost = sync_lost_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Randomised self-checking bench for lfsr_prbs_checker against a
// behavioural model of the synchronisation rules.
module tb_lfsr_prbs_checker;

  localparam int SYNC = 4;
  localparam int LOSS = 3;
  localparam int TAP_INT = 8'hCF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [8:1]  in_state = '0;
  logic        clr_count = 1'b0;

  logic        locked, err_pulse, sync_lost;
  logic [15:0] err_count;
  logic        locked_s, err_pulse_s, sync_lost_s;
  logic [2:0]  err_count_s;

  int checks = 0;
  int fails = 0;

  // model of the checker behaviour
  int m_pred, m_run, m_miss, m_cnt, m_cnt3;
  bit m_track, m_lock, m_pulse, m_lost;
  int gen;

  always #5 clk = ~clk;

  lfsr_prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state),
    .clr_count(clr_count), .locked(locked), .err_pulse(err_pulse),
    .sync_lost(sync_lost), .err_count(err_count)
  );

  lfsr_prbs_checker #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state),
    .clr_count(clr_count), .locked(locked_s), .err_pulse(err_pulse_s),
    .sync_lost(sync_lost_s), .err_count(err_count_s)
  );

  function automatic int step_model(int y);
    int mask = 0;
    int n;
    for (int k = 2; k <= 8; k++)
      if (((TAP_INT >> (8 - k)) & 1) != 0) mask = mask | (1 << (k - 1));
    n = ((y << 1) & 255) | ((y >> 7) & 1);
    if ((y & 128) != 0) n = n ^ mask;
    return n;
  endfunction

  task automatic model_reset();
    m_pred = 0; m_run = 0; m_miss = 0; m_cnt = 0; m_cnt3 = 0;
    m_track = 0; m_lock = 0; m_pulse = 0; m_lost = 0;
  endtask

  task automatic model_sample(bit v, int s, bit c);
    m_pulse = 0;
    m_lost = 0;
    if (c) begin m_cnt = 0; m_cnt3 = 0; end
    if (!v) return;
    if (m_lock) begin
      if (s != m_pred) begin
        m_pulse = 1;
        if (!c) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt3 < 7) m_cnt3++;
        end
        m_miss++;
        if (m_miss == LOSS) begin m_lock = 0; m_lost = 1; m_miss = 0; end
      end else begin
        m_miss = 0;
      end
      m_pred = step_model(m_pred);
    end else if (!m_track) begin
      if (s != 0) begin m_pred = step_model(s); m_run = 0; m_track = 1; end
    end else if (s == m_pred) begin
      m_pred = step_model(s);
      m_run++;
      if (m_run == SYNC) begin m_lock = 1; m_track = 0; m_miss = 0; end
    end else if (s != 0) begin
      m_pred = step_model(s);
      m_run = 0;
    end else begin
      m_track = 0;
    end
  endtask

  task automatic drive(bit v, int s, bit c);
    @(negedge clk);
    in_valid = v;
    in_state = s[7:0];
    clr_count = c;
    model_sample(v, s, c);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_count = 1'b0;
    in_state = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    gen = 8'h91;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL reset: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need all zero",
               locked, err_pulse, sync_lost, err_count, err_count_s);
    end
    pulse_reset();
  endtask

  task automatic test_acquire();
    for (int i = 0; i < 8; i++) begin
      drive(1, gen, 0);
      gen = step_model(gen);
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL acquire %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 6; i++) begin
      drive(1, (i == 1) ? (gen ^ (1 + int'($urandom_range(0, 254)))) : gen, 0);
      gen = step_model(gen);
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL single_error %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
  endtask

  task automatic test_loss_relock();
    for (int i = 0; i < 11; i++) begin
      drive(1, (i < 3) ? (gen ^ (1 + int'($urandom_range(0, 254)))) : gen, 0);
      gen = step_model(gen);
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL loss_relock %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
  endtask

  task automatic test_zero_hunt();
    int zeros;
    pulse_reset();
    zeros = 2 + int'($urandom_range(0, 3));
    for (int i = 0; i < zeros + 7; i++) begin
      if (i < zeros) begin
        drive(1, 0, 0);
      end else begin
        drive(1, gen, 0);
        gen = step_model(gen);
      end
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL zero_hunt %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
  endtask

  task automatic test_valid_toggle();
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        drive(1, gen, 0);
        gen = step_model(gen);
      end else begin
        drive(0, int'($urandom_range(0, 255)), 0);
      end
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL valid_toggle %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
  endtask

  task automatic test_saturation();
    bit bad;
    bit clr;
    pulse_reset();
    // 5 samples to lock, then (err, err, match) x4, then clr with an error, then a match
    for (int i = 0; i < 19; i++) begin
      bad = (i >= 5 && i < 17 && ((i - 5) % 3) != 2) || (i == 17);
      clr = (i == 17);
      drive(1, bad ? (gen ^ (1 + int'($urandom_range(0, 254)))) : gen, clr);
      gen = step_model(gen);
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL saturation %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
    // error to make the counter nonzero, then async reset between edges
    drive(1, gen ^ 8'h01, 0);
    gen = step_model(gen);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !== 25'd0) begin
      fails++;
      $display("[TB] FAIL async_reset: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need all zero",
               locked, err_pulse, sync_lost, err_count, err_count_s);
    end
  endtask

  task automatic test_back_to_back();
    bit v;
    bit c;
    int w;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      v = (i < 5) || ($urandom_range(0, 3) != 0);
      c = (i >= 5) && ($urandom_range(0, 39) == 0);
      w = gen;
      if (i >= 5 && $urandom_range(0, 5) == 0) w = gen ^ int'($urandom_range(1, 255));
      drive(v, v ? w : int'($urandom_range(0, 255)), c);
      if (v) gen = step_model(gen);
      checks++;
      if ({locked, err_pulse, sync_lost, err_count, locked_s, err_pulse_s, sync_lost_s, err_count_s} !==
          {m_lock, m_pulse, m_lost, 16'(m_cnt), m_lock, m_pulse, m_lost, 3'(m_cnt3)}) begin
        fails++;
        $display("[TB] FAIL back_to_back %0d: got lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h, need lk=%0b ep=%0b sl=%0b cnt=%h cnt3=%h",
                 i, locked, err_pulse, sync_lost, err_count, err_count_s, m_lock, m_pulse, m_lost, m_cnt, m_cnt3);
      end
    end
  endtask

  initial begin
    gen = 8'h91;
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_relock();
    test_zero_hunt();
    test_valid_toggle();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
